// File: rtl/asyn_fifo_arb_pkg.sv
// Shared types and constants for the asynchronous-FIFO write arbiter.
// Optional feature macro used by the arbiter: ASYN_FIFO_ARB_CNT_EN
// (per-requester accepted-word counters).

`ifndef DSIZE
`define DSIZE 8
`endif

package asyn_fifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates (one-cycle bubble), BURST streams words.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of each per-requester accepted-word counter.
    localparam int ARB_CNT_W = 16;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
        return (v == {ARB_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/asyn_fifo_rr_pick.sv
// Combinational round-robin first-one search: starting at rr_ptr and
// wrapping, returns the first requester with req_valid high.

module asyn_fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [IW-1:0]      rr_ptr,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [IW-1:0]      index,
    output logic               found
);

    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        index = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IW'((int'(rr_ptr) + off) % NUM_REQ);
            if (req_valid[cand]) begin
                index = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/asyn_fifo_wr_arb.sv
// Round-robin write arbiter in front of an asynchronous FIFO write port.
// Grants one requester at a time for bursts of up to MAX_BURST words,
// never writes into a full FIFO, and inserts one arbitration bubble per
// grant. Define ASYN_FIFO_ARB_CNT_EN to add cnt_clr / acc_cnt
// (saturating per-requester accepted-word counters).

`ifndef DSIZE
`define DSIZE 8
`endif

module asyn_fifo_wr_arb
    import asyn_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int DSIZE     = `DSIZE,
    localparam int GW       = $clog2(NUM_REQ)
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DSIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DSIZE-1:0]           wdata,
    output logic [GW-1:0]              grant_id,
    output logic                       busy
`ifdef ASYN_FIFO_ARB_CNT_EN
    ,
    input  logic                       cnt_clr,
    output logic [NUM_REQ*ARB_CNT_W-1:0] acc_cnt
`endif
);

    // Beat counter must hold MAX_BURST itself after the last increment.
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    arb_state_t    state, state_nxt;
    logic [GW-1:0] rr_ptr, rr_nxt;
    logic [GW-1:0] grant_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          accept;

    asyn_fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .rr_ptr    (rr_ptr),
        .req_valid (req_valid),
        .index     (pick_idx),
        .found     (pick_found)
    );

    // Next-state, handshake and FIFO write outputs for the arbiter FSM.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BURST;
                    grant_nxt = pick_idx;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                req_ready[grant_id] = ~wfull;
                wdata  = req_data[grant_id*DSIZE +: DSIZE];
                accept = req_valid[grant_id] & ~wfull;
                winc   = accept;
                if (accept) begin
                    beat_nxt = beat_cnt + 1'b1;
                end
                // A dropped requester ends the burst even during a full stall.
                if (!req_valid[grant_id] || (accept && beat_cnt == LAST_BEAT)) begin
                    state_nxt = IDLE;
                    rr_nxt    = GW'((int'(grant_id) + 1) % NUM_REQ);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter state registers; reset abandons any partial burst.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    assign busy = (state == BURST);

`ifdef ASYN_FIFO_ARB_CNT_EN
    logic [ARB_CNT_W-1:0] cnt_q [NUM_REQ];

    // Per-requester accepted-word counters; clear beats a same-cycle increment.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            // NOTE: this small register array is software-visible state, so
            // it is reset explicitly rather than left to power-up values.
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (accept && grant_id == GW'(i)) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign acc_cnt[g*ARB_CNT_W +: ARB_CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_asyn_fifo_wr_arb.sv
// Scoreboard bench for asyn_fifo_wr_arb: directed scenarios push expected
// (cycle, grant) beats; a negedge monitor pops and compares on every winc.
// Counter checks are compiled only with ASYN_FIFO_ARB_CNT_EN.

`ifndef DSIZE
`define DSIZE 8
`endif

module tb_asyn_fifo_wr_arb;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;
    localparam int DW        = `DSIZE;
    localparam int GW        = 2;

    logic                     wclk   = 1'b0;
    logic                     wrst_n = 1'b1;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DW-1:0]    req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     wfull;
    logic                     winc;
    logic [DW-1:0]            wdata;
    logic [GW-1:0]            grant_id;
    logic                     busy;
`ifdef ASYN_FIFO_ARB_CNT_EN
    logic                     cnt_clr;
    logic [NUM_REQ*16-1:0]    acc_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int id;
    } exp_t;

    exp_t sb[$];

    asyn_fifo_wr_arb #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST),
        .DSIZE     (DW)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef ASYN_FIFO_ARB_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .acc_cnt   (acc_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    // Fixed word offered by each requester.
    function automatic logic [DW-1:0] word(input int i);
        return DW'(32'hA0 + 32'h11 * i);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_burst(input int start, input int id, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{cyc: start + k, id: id});
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        wrst_n    = 1'b0;
        req_valid = '0;
        wfull     = 1'b0;
        repeat (2) tick();
        wrst_n = 1'b1;
        tick();
    endtask

    // Monitor: every FIFO write must match the next expected beat.
    always @(negedge wclk) begin
        exp_t e;
        if (winc) begin
            if (sb.size() == 0) begin
                check("unexpected_winc", 1, 0);
            end else begin
                e = sb.pop_front();
                check("beat_cycle", cyc, e.cyc);
                check("beat_grant", grant_id, e.id);
                check("beat_data", wdata, word(e.id));
            end
            check("winc_while_full", wfull, 0);
            check("ready_at_beat", req_ready[grant_id], 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        req_valid = '0;
        wfull     = 1'b0;
`ifdef ASYN_FIFO_ARB_CNT_EN
        cnt_clr   = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = word(i);

        // Reset state with all requesters valid.
        #1;
        wrst_n    = 1'b0;
        req_valid = '1;
        #2;
        check("rst_winc", winc, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_wdata", wdata, 0);

        // Requesters 0,1,2 continuously valid: 4 beats each with bubbles.
        do_reset();
        c0 = cyc;
        req_valid = 4'b0111;
        #1;
        check("bubble_first_busy", busy, 0);
        check("bubble_first_ready", req_ready, 0);
        push_burst(c0 + 1, 0, 4);
        push_burst(c0 + 6, 1, 4);
        push_burst(c0 + 11, 2, 4);
        push_burst(c0 + 16, 0, 1);
        goto(c0 + 5);
        #1;
        check("bubble_mid_busy", busy, 0);
        check("bubble_mid_ready", req_ready, 0);
        goto(c0 + 17);
        req_valid = '0;
        goto(c0 + 19);
        check("rr_sb_empty", sb.size(), 0);

        // Only requester 3 valid: grant 3, wrap to pointer 0, re-grant 3.
        do_reset();
        c0 = cyc;
        req_valid = 4'b1000;
        push_burst(c0 + 1, 3, 4);
        push_burst(c0 + 6, 3, 4);
        goto(c0 + 1);
        #1;
        check("solo_grant", grant_id, 3);
        check("solo_busy", busy, 1);
        goto(c0 + 10);
        req_valid = '0;
        goto(c0 + 12);
        check("solo_sb_empty", sb.size(), 0);

        // Five-cycle full stall after beat 2, then beats 3 and 4.
        do_reset();
        c0 = cyc;
        req_valid = 4'b0001;
        push_burst(c0 + 1, 0, 2);
        push_burst(c0 + 8, 0, 2);
        for (int k = 0; k < 5; k++) begin
            goto(c0 + 3 + k);
            if (k == 0) wfull = 1'b1;
            #1;
            check("stall_winc", winc, 0);
            check("stall_ready", req_ready, 0);
            check("stall_busy", busy, 1);
        end
        goto(c0 + 8);
        wfull = 1'b0;
        goto(c0 + 10);
        #1;
        check("stall_exit", busy, 0);
        req_valid = '0;
        goto(c0 + 12);
        check("stall_sb_empty", sb.size(), 0);

        // Requester 1 drops after one beat while FIFO is full: exit, then req 2.
        do_reset();
        c0 = cyc;
        req_valid = 4'b0110;
        push_burst(c0 + 1, 1, 1);
        push_burst(c0 + 4, 2, 4);
        goto(c0 + 2);
        req_valid[1] = 1'b0;
        wfull        = 1'b1;
        #1;
        check("drop_winc", winc, 0);
        goto(c0 + 3);
        wfull = 1'b0;
        #1;
        check("drop_exit", busy, 0);
        goto(c0 + 4);
        #1;
        check("drop_next_grant", grant_id, 2);
        goto(c0 + 8);
        req_valid = '0;
        goto(c0 + 10);
        check("drop_sb_empty", sb.size(), 0);

        // Reset at beat 2 of requester 1's burst; restart from requester 0.
        do_reset();
        c0 = cyc;
        req_valid = 4'b0011;
        push_burst(c0 + 1, 0, 4);
        push_burst(c0 + 6, 1, 2);
        goto(c0 + 7);
        #5;
        wrst_n = 1'b0;
        #1;
        check("midrst_winc", winc, 0);
        check("midrst_busy", busy, 0);
        check("midrst_grant", grant_id, 0);
        check("midrst_ready", req_ready, 0);
        check("midrst_wdata", wdata, 0);
        req_valid = '1;
        tick();
        tick();
        wrst_n = 1'b1;
        c1 = cyc;
        push_burst(c1 + 1, 0, 4);
        goto(c1 + 1);
        #1;
        check("post_rst_grant", grant_id, 0);
        goto(c1 + 5);
        req_valid = '0;
        goto(c1 + 7);
        check("midrst_sb_empty", sb.size(), 0);

`ifdef ASYN_FIFO_ARB_CNT_EN
        // Ten beats from requester 2, then clear together with an accept.
        do_reset();
        c0 = cyc;
        req_valid = 4'b0100;
        push_burst(c0 + 1, 2, 4);
        push_burst(c0 + 6, 2, 4);
        push_burst(c0 + 11, 2, 2);
        goto(c0 + 13);
        req_valid = '0;
        #1;
        check("cnt_req2", acc_cnt[2*16 +: 16], 10);
        check("cnt_req0", acc_cnt[0 +: 16], 0);
        check("cnt_req3", acc_cnt[3*16 +: 16], 0);
        goto(c0 + 15);
        req_valid = 4'b0100;
        push_burst(c0 + 16, 2, 1);
        goto(c0 + 16);
        cnt_clr = 1'b1;
        goto(c0 + 17);
        cnt_clr   = 1'b0;
        req_valid = '0;
        #1;
        check("cnt_clr_wins", acc_cnt[2*16 +: 16], 0);
        goto(c0 + 19);
        check("cnt_sb_empty", sb.size(), 0);
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
